// File: rtl/vit_pkg.sv
// Shared types and default sizing for the 64-state hard-decision Viterbi decoder.
package vit_pkg;

    localparam int NUM_STATES  = 64;
    localparam int ACS_PER_CYC = 8;
    localparam int FRAME_LEN   = 256;
    localparam int G           = NUM_STATES / ACS_PER_CYC;
    localparam int GRP_W       = $clog2(G);
    localparam int STG_W       = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        ACCEPT = 2'd1,
        RUN    = 2'd2,
        TB     = 2'd3
    } sched_state_t;

endpackage

// File: rtl/vit_stage_cnt.sv
// Group and trellis-stage counters for the ACS scheduler, with wrap flags.
module vit_stage_cnt #(
    parameter int G         = 8,
    parameter int FRAME_LEN = 256,
    localparam int GRP_W    = $clog2(G),
    localparam int STG_W    = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             grp_clr,
    input  logic             step,
    output logic [GRP_W-1:0] grp,
    output logic [STG_W-1:0] stage,
    output logic             last_grp,
    output logic             last_stage
);

    assign last_grp   = (grp == GRP_W'(G - 1));
    assign last_stage = (stage == STG_W'(FRAME_LEN - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            grp   <= '0;
            stage <= '0;
        end else begin
            if (grp_clr)
                grp <= '0;
            else if (step)
                grp <= last_grp ? '0 : grp + 1'b1;
            // Stage advances once per completed sweep over all groups
            if (step && last_grp)
                stage <= last_stage ? '0 : stage + 1'b1;
        end
    end

endmodule

// File: rtl/vit_acs_sched.sv
// Frame scheduler time-multiplexing the shared BMC/ACS array over all trellis states.
// Optional metric normalization is compiled in with VIT_SCHED_NORM_EN.
module vit_acs_sched
    import vit_pkg::*;
#(
    parameter int NUM_STATES  = 64,
    parameter int ACS_PER_CYC = 8,
    parameter int FRAME_LEN   = 256,
    localparam int G          = NUM_STATES / ACS_PER_CYC,
    localparam int GRP_W      = $clog2(G),
    localparam int STG_W      = $clog2(FRAME_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [1:0]             rx_pair,
    output logic                   rx_ready,
    output logic [1:0]             acs_rx_pair,
    output logic [GRP_W-1:0]       acs_grp,
    output logic                   acs_en,
    output logic                   pm_bank_sel,
    output logic                   sm_wr_en,
    output logic [STG_W+GRP_W-1:0] sm_wr_addr,
    input  logic                   norm_req,
    output logic                   norm_en,
    output logic                   pm_init,
    output logic                   tb_start,
    input  logic                   tb_done
);

    sched_state_t     state_q, state_d;
    logic [GRP_W-1:0] grp;
    logic [STG_W-1:0] stage;
    logic             last_grp, last_stage;
    logic             in_tb_q;

    wire accept    = (state_q == ACCEPT) && rx_valid;
    wire run       = (state_q == RUN);
    wire stage_end = run && last_grp;
    wire tb_first  = (state_q == TB) && !in_tb_q;

    vit_stage_cnt #(.G(G), .FRAME_LEN(FRAME_LEN)) u_cnt (
        .clk        (clk),
        .clr        (rst),
        .grp_clr    (accept),
        .step       (run),
        .grp        (grp),
        .stage      (stage),
        .last_grp   (last_grp),
        .last_stage (last_stage)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = ACCEPT;
            ACCEPT:  if (rx_valid) state_d = RUN;
            RUN:     if (last_grp) state_d = last_stage ? TB : ACCEPT;
            // tb_done in the tb_start cycle belongs to the previous handoff
            TB:      if (!tb_first && tb_done) state_d = INIT;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        rx_ready   = (state_q == ACCEPT);
        acs_en     = run;
        sm_wr_en   = run;
        acs_grp    = run ? grp : '0;
        sm_wr_addr = run ? {stage, grp} : '0;
        pm_init    = (state_q == INIT);
        tb_start   = tb_first;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acs_rx_pair <= 2'b00;
            pm_bank_sel <= 1'b0;
            in_tb_q     <= 1'b0;
        end else begin
            if (accept)    acs_rx_pair <= rx_pair;
            if (stage_end) pm_bank_sel <= ~pm_bank_sel;
            in_tb_q <= (state_q == TB);
        end
    end

`ifdef VIT_SCHED_NORM_EN
    logic norm_flag;

    // A request seen in the closing cycle folds straight into the next stage's norm_en
    always_ff @(posedge clk) begin
        if (rst) begin
            norm_flag <= 1'b0;
            norm_en   <= 1'b0;
        end else if (stage_end) begin
            norm_en   <= norm_flag | norm_req;
            norm_flag <= 1'b0;
        end else if (run && norm_req) begin
            norm_flag <= 1'b1;
        end
    end
`else
    logic unused_norm_req;
    assign unused_norm_req = norm_req;
    assign norm_en         = 1'b0;
`endif

endmodule

// File: tb/tb_vit_acs_sched.sv
// Directed self-checking bench for vit_acs_sched with FRAME_LEN=4 (8 groups per stage).
module tb_vit_acs_sched;

    localparam int GRP_W = 3;
    localparam int STG_W = 2;
`ifdef VIT_SCHED_NORM_EN
    localparam logic NORM_ON = 1'b1;
`else
    localparam logic NORM_ON = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   rx_valid = 1'b0;
    logic [1:0]             rx_pair = 2'b00;
    logic                   norm_req = 1'b0;
    logic                   tb_done = 1'b0;
    logic                   rx_ready, acs_en, pm_bank_sel, sm_wr_en, norm_en, pm_init, tb_start;
    logic [1:0]             acs_rx_pair;
    logic [GRP_W-1:0]       acs_grp;
    logic [STG_W+GRP_W-1:0] sm_wr_addr;

    int errors = 0;
    int checks = 0;

    vit_acs_sched #(.NUM_STATES(64), .ACS_PER_CYC(8), .FRAME_LEN(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_pair     (rx_pair),
        .rx_ready    (rx_ready),
        .acs_rx_pair (acs_rx_pair),
        .acs_grp     (acs_grp),
        .acs_en      (acs_en),
        .pm_bank_sel (pm_bank_sel),
        .sm_wr_en    (sm_wr_en),
        .sm_wr_addr  (sm_wr_addr),
        .norm_req    (norm_req),
        .norm_en     (norm_en),
        .pm_init     (pm_init),
        .tb_start    (tb_start),
        .tb_done     (tb_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; rx_valid = 1'b0; norm_req = 1'b0; tb_done = 1'b0;
        tick; tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        logic [15:0] outs;
        rst = 1'b1; rx_valid = 1'b0; norm_req = 1'b0; tb_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (pm_init !== 1'b1) begin errors++; $display("FAIL reset_pm_init_held: got %b want 1", pm_init); end
        end
        outs = {rx_ready, acs_en, sm_wr_en, tb_start, pm_bank_sel, norm_en, acs_rx_pair, acs_grp, sm_wr_addr};
        checks++;
        if (outs !== 16'h0) begin errors++; $display("FAIL reset_outputs: got %h want 0000", outs); end
        rst = 1'b0;
        #1;
        checks++;
        if (pm_init !== 1'b1) begin errors++; $display("FAIL reset_pm_init_release: got %b want 1", pm_init); end
        tick;
        checks++;
        if (rx_ready !== 1'b1 || pm_init !== 1'b0) begin
            errors++; $display("FAIL reset_accept: rx_ready=%b pm_init=%b want 1/0", rx_ready, pm_init);
        end
    endtask

    task automatic test_single_symbol;
        do_reset;
        rx_valid = 1'b1; rx_pair = 2'b10;
        #1;
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", rx_ready); end
        tick;
        rx_valid = 1'b0; rx_pair = 2'b01;
        for (int g = 0; g < 8; g++) begin
            checks++;
            if (acs_en !== 1'b1 || sm_wr_en !== 1'b1 || acs_grp !== GRP_W'(g) || sm_wr_addr !== 5'(g)
                || acs_rx_pair !== 2'b10 || pm_bank_sel !== 1'b0 || rx_ready !== 1'b0) begin
                errors++;
                $display("FAIL single_run g=%0d: en=%b wr=%b grp=%0d addr=%0d pair=%b bank=%b rdy=%b want 1/1/%0d/%0d/10/0/0",
                         g, acs_en, sm_wr_en, acs_grp, sm_wr_addr, acs_rx_pair, pm_bank_sel, rx_ready, g, g);
            end
            tick;
        end
        checks++;
        if (pm_bank_sel !== 1'b1 || acs_en !== 1'b0 || rx_ready !== 1'b1 || acs_rx_pair !== 2'b10 || acs_grp !== 3'd0) begin
            errors++;
            $display("FAIL single_after: bank=%b en=%b rdy=%b pair=%b grp=%0d want 1/0/1/10/0",
                     pm_bank_sel, acs_en, rx_ready, acs_rx_pair, acs_grp);
        end
    endtask

    task automatic test_full_frame;
        int max_addr;
        int starts;
        max_addr = 0;
        starts = 0;
        do_reset;
        rx_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            rx_pair = 2'(s);
            checks++;
            if (rx_ready !== 1'b1) begin errors++; $display("FAIL frame_ready s=%0d: got %b want 1", s, rx_ready); end
            tick;
            for (int g = 0; g < 8; g++) begin
                checks++;
                if (acs_en !== 1'b1 || sm_wr_addr !== 5'(s * 8 + g) || acs_rx_pair !== 2'(s) || tb_start !== 1'b0) begin
                    errors++;
                    $display("FAIL frame_run s=%0d g=%0d: en=%b addr=%0d pair=%0d tbs=%b want 1/%0d/%0d/0",
                             s, g, acs_en, sm_wr_addr, acs_rx_pair, tb_start, s * 8 + g, s);
                end
                if (int'(sm_wr_addr) > max_addr) max_addr = int'(sm_wr_addr);
                tick;
            end
        end
        rx_valid = 1'b0;
        if (tb_start === 1'b1) starts++;
        checks++;
        if (tb_start !== 1'b1 || rx_ready !== 1'b0 || acs_en !== 1'b0 || pm_bank_sel !== 1'b0) begin
            errors++;
            $display("FAIL frame_tb_entry: tbs=%b rdy=%b en=%b bank=%b want 1/0/0/0", tb_start, rx_ready, acs_en, pm_bank_sel);
        end
        checks++;
        if (max_addr !== 31) begin errors++; $display("FAIL frame_max_addr: got %0d want 31", max_addr); end
        for (int k = 1; k <= 5; k++) begin
            tick;
            if (tb_start === 1'b1) starts++;
            checks++;
            if (rx_ready !== 1'b0 || pm_init !== 1'b0 || acs_en !== 1'b0) begin
                errors++; $display("FAIL frame_tb_wait k=%0d: rdy=%b init=%b en=%b want 0/0/0", k, rx_ready, pm_init, acs_en);
            end
        end
        checks++;
        if (starts !== 1) begin errors++; $display("FAIL frame_tb_start_count: got %0d want 1", starts); end
        tb_done = 1'b1;
        tick;
        tb_done = 1'b0;
        checks++;
        if (pm_init !== 1'b1 || rx_ready !== 1'b0) begin
            errors++; $display("FAIL frame_init: init=%b rdy=%b want 1/0", pm_init, rx_ready);
        end
        tick;
        checks++;
        if (rx_ready !== 1'b1 || pm_init !== 1'b0) begin
            errors++; $display("FAIL frame_reaccept: rdy=%b init=%b want 1/0", rx_ready, pm_init);
        end
    endtask

    task automatic test_tb_done_early;
        do_reset;
        rx_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick;
            repeat (8) tick;
        end
        rx_valid = 1'b0;
        checks++;
        if (tb_start !== 1'b1) begin errors++; $display("FAIL early_tb_start: got %b want 1", tb_start); end
        tb_done = 1'b1;
        tick;
        checks++;
        if (pm_init !== 1'b0 || rx_ready !== 1'b0 || tb_start !== 1'b0 || acs_en !== 1'b0) begin
            errors++;
            $display("FAIL early_ignored: init=%b rdy=%b tbs=%b en=%b want 0/0/0/0", pm_init, rx_ready, tb_start, acs_en);
        end
        tick;
        tb_done = 1'b0;
        checks++;
        if (pm_init !== 1'b1) begin errors++; $display("FAIL early_to_init: got %b want 1", pm_init); end
    endtask

    task automatic test_norm;
        do_reset;
        rx_valid = 1'b1;
        tick;
        for (int g = 0; g < 8; g++) begin
            norm_req = (g == 7);
            checks++;
            if (norm_en !== 1'b0) begin errors++; $display("FAIL norm_stage0 g=%0d: got %b want 0", g, norm_en); end
            tick;
        end
        norm_req = 1'b0;
        tick;
        for (int g = 0; g < 8; g++) begin
            checks++;
            if (norm_en !== NORM_ON) begin errors++; $display("FAIL norm_stage1 g=%0d: got %b want %b", g, norm_en, NORM_ON); end
            tick;
        end
        tick;
        rx_valid = 1'b0;
        for (int g = 0; g < 8; g++) begin
            checks++;
            if (norm_en !== 1'b0) begin errors++; $display("FAIL norm_stage2 g=%0d: got %b want 0", g, norm_en); end
            tick;
        end
    endtask

    task automatic test_rst_mid_run;
        do_reset;
        rx_valid = 1'b1;
        tick;
        repeat (8) tick;
        tick;
        repeat (3) tick;
        rx_valid = 1'b0;
        checks++;
        if (acs_grp !== 3'd3 || sm_wr_addr !== 5'd11 || pm_bank_sel !== 1'b1) begin
            errors++;
            $display("FAIL midrst_before: grp=%0d addr=%0d bank=%b want 3/11/1", acs_grp, sm_wr_addr, pm_bank_sel);
        end
        rst = 1'b1;
        tick;
        checks++;
        if (pm_init !== 1'b1 || acs_en !== 1'b0 || pm_bank_sel !== 1'b0) begin
            errors++; $display("FAIL midrst_init: init=%b en=%b bank=%b want 1/0/0", pm_init, acs_en, pm_bank_sel);
        end
        rst = 1'b0;
        tick;
        rx_valid = 1'b1; rx_pair = 2'b11;
        tick;
        rx_valid = 1'b0;
        checks++;
        if (acs_en !== 1'b1 || sm_wr_addr !== 5'd0 || acs_grp !== 3'd0 || acs_rx_pair !== 2'b11) begin
            errors++;
            $display("FAIL midrst_restart: en=%b addr=%0d grp=%0d pair=%b want 1/0/0/11", acs_en, sm_wr_addr, acs_grp, acs_rx_pair);
        end
    endtask

    initial begin
        test_reset;
        test_single_symbol;
        test_full_frame;
        test_tb_done_early;
        test_norm;
        test_rst_mid_run;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vit_acs_sched.md
# vit_acs_sched

Frame-level scheduler for the 64-state hard-decision Viterbi decoder. Accepts received 2-bit symbol pairs over a valid/ready handshake and time-multiplexes the shared BMC/ACS array over all states, ACS_PER_CYC states per cycle. Drives path-metric bank ping-pong, survivor-memory writes and metric normalization. At each frame end it hands off to traceback. Sits between the channel input FIFO and the BMC/ACS/survivor datapath.

## Interface
- NUM_STATES, 64: trellis states; power of two.
- ACS_PER_CYC, 8: states updated per cycle; divides NUM_STATES. G = NUM_STATES/ACS_PER_CYC groups.
- FRAME_LEN, 256: trellis stages per frame; power of two, at least 2.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- rx_valid  in  1  symbol pair available.
- rx_pair  in  2  hard-decision pair.
- rx_ready  out  1  scheduler can accept a symbol.
- acs_rx_pair  out  2  captured symbol, held for the whole stage.
- acs_grp  out  clog2(G)  state group being updated.
- acs_en  out  1  ACS array updates group acs_grp this cycle.
- pm_bank_sel  out  1  path-metric read bank; write bank = ~pm_bank_sel.
- sm_wr_en  out  1  survivor write strobe.
- sm_wr_addr  out  clog2(FRAME_LEN)+clog2(G)  {stage, acs_grp}.
- norm_req  in  1  some newly written metric has MSB set.
- norm_en  out  1  ACS subtracts 2^(PM_W-1) from every read metric this stage.
- pm_init  out  1  ACS loads initial metrics (state 0 = 0, others = max).
- tb_start  out  1  single-cycle pulse to traceback.
- tb_done  in  1  traceback has finished reading survivors.

## Operation
- FSM states: INIT, ACCEPT, RUN, TB. rst forces INIT from any state, including mid-stage and mid-traceback. rst clears stage and grp counters, pm_bank_sel and the normalization flag.
- INIT: lasts one cycle with pm_init=1. Next state is ACCEPT. pm_init stays 1 while rst is held.
- ACCEPT: rx_ready=1. When rx_valid=1, capture rx_pair into acs_rx_pair, set grp=0 and go to RUN. Otherwise stay.
- RUN: lasts exactly G cycles. Each cycle: acs_en=1, sm_wr_en=1, sm_wr_addr={stage, grp}, then grp increments.
- Last RUN cycle (grp=G-1):
  - toggle pm_bank_sel;
  - latch norm_en <= norm_flag and clear norm_flag;
  - if stage=FRAME_LEN-1: go to TB and set stage=0;
  - else: increment stage and go to ACCEPT.
- norm_req is sampled in every RUN cycle and ORed into the sticky norm_flag. If norm_req=1 in the last RUN cycle, it still counts for the next stage. norm_en stays constant for the whole stage it applies to.
- TB:
  - tb_start=1 in the first TB cycle only.
  - tb_done is ignored in that first cycle. From the second TB cycle on, tb_done=1 sends the FSM to INIT, which re-initialises metrics for the next frame.
  - rx_ready=0 throughout TB.
- Outputs in states where they are not asserted above:
  - acs_en, sm_wr_en, tb_start, rx_ready = 0;
  - pm_init = 0 outside INIT;
  - acs_grp = 0;
  - acs_rx_pair holds its last value (reset value 0).
- Reset values: pm_init=1 (state INIT); all other outputs 0.

## Timing
- Symbol accepted at cycle t. RUN occupies t+1 … t+G. ACCEPT is next active at t+G+1.
- Throughput: one symbol per G+1 cycles (9 with defaults).
- Survivor bits for stage s, group g are written at cycle t+1+g.
- pm_bank_sel changes on the edge after the last RUN cycle, so the next stage reads the bank just written.
- Frame cost: FRAME_LEN·(G+1) cycles + 1 INIT cycle + the traceback wait.
- acs_rx_pair changes only on an accepting edge.

## Configuration
- VIT_SCHED_NORM_EN defined: normalization logic (norm_flag and norm_en) is compiled in.
- VIT_SCHED_NORM_EN undefined: norm_en is tied to 0 and norm_req is ignored. The datapath must then size PM_W for FRAME_LEN without overflow.

## Structure
- Shared package vit_pkg holds:
  - NUM_STATES;
  - the FSM state enum (INIT, ACCEPT, RUN, TB);
  - localparams G, GRP_W = clog2(G), STG_W = clog2(FRAME_LEN).
- One sub-module: vit_stage_cnt. It holds the grp and stage counters with last_grp and last_stage flags and a synchronous clear. The FSM, normalization flag and bank select stay in vit_acs_sched.

## Test plan
All scenarios use NUM_STATES=64, ACS_PER_CYC=8, FRAME_LEN=4 unless stated.
- Reset: hold rst 3 cycles, then release.
  - Required: pm_init=1 while rst is held and for the first cycle after release.
  - Required: rx_ready=1 on the second cycle after release.
- Single symbol: rx_pair=2'b10 accepted at cycle t.
  - Required: acs_en=1 on cycles t+1..t+8, acs_grp=0..7, sm_wr_addr=0..7, acs_rx_pair=2'b10.
  - Required: pm_bank_sel=1 from t+9.
- Full frame, rx_valid held high: 4 symbols accepted 9 cycles apart.
  - Required: tb_start pulses once on the cycle after the last RUN; sm_wr_addr reaches 31.
  - Required: with tb_done asserted 5 cycles later, one INIT cycle, then rx_ready=1.
- tb_done asserted in the same cycle as tb_start: ignored, FSM stays in TB. tb_done next cycle: FSM goes to INIT.
- Normalization (macro defined): norm_req=1 only at grp=7 of stage 0.
  - Required: norm_en=1 for all of stage 1's RUN cycles, 0 in stage 2.
  - Required (macro undefined): norm_en is always 0.
- rst asserted at RUN grp=3.
  - Required: next cycle is INIT, acs_en=0, pm_bank_sel=0; the next accepted symbol uses sm_wr_addr starting at 0.
